// File: rtl/cereal_rx.sv
// cereal_rx: idle-high 8N1 LSB-first serial receiver with a first-word-fall-through output buffer.
// Define CEREAL_RX_FIFO_EN for a 2**FIFO_AW deep FIFO; otherwise a single holding register is used.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 78105,
  parameter int FIFO_AW      = 4
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             rxd,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic [FIFO_AW:0] level,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow
);
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic          rx_meta_q, rx_s_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          push;
  logic          do_push, do_pop;
  logic [7:0]    rd_data_q;
  logic          overflow_q;

  // NOTE: non-blocking assignments make each flop take its pre-edge input; blocking ones would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      cnt_q       <= cnt_q + CNT_ONE;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == HALF_CNT) begin
          // A high line at mid start bit was only a glitch.
          state_q   <= rx_s_q ? IDLE : DATA;
          cnt_q     <= '0;
          bit_idx_q <= '0;
        end
        DATA: if (cnt_q == FULL_CNT) begin
          shift_q   <= {rx_s_q, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          cnt_q     <= '0;
          if (bit_idx_q == 3'd7) state_q <= STOP;
        end
        STOP: if (cnt_q == FULL_CNT) begin
          frame_err_q <= !rx_s_q;
          state_q     <= IDLE;
          cnt_q       <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push      = (state_q == STOP) && (cnt_q == FULL_CNT) && rx_s_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign rd_data   = rd_data_q;
  assign overflow  = overflow_q;

`ifdef CEREAL_RX_FIFO_EN
  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [FIFO_AW:0]   level_q;
  logic               full;

  assign full    = (level_q == LVL_FULL);
  assign do_pop  = rd_en && (level_q != '0);
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr_q + PTR_ONE;

  // NOTE: the storage array is deliberately not reset; pointers and level alone say which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      if (push && full && !do_pop) overflow_q <= 1'b1;
      // Head register: holds its last value once the FIFO drains.
      if (do_pop) begin
        if (level_q != LVL_ONE) rd_data_q <= mem_q[rd_nxt];
        else if (do_push)       rd_data_q <= shift_q;
      end else if ((level_q == '0) && do_push) begin
        rd_data_q <= shift_q;
      end
    end
  end

  assign level = level_q;
  assign empty = (level_q == '0);
`else
  logic valid_q;

  assign do_pop  = rd_en && valid_q;
  assign do_push = push && (!valid_q || do_pop);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        rd_data_q <= shift_q;
        valid_q   <= 1'b1;
      end else if (do_pop) begin
        valid_q   <= 1'b0;
      end
      if (push && valid_q && !do_pop) overflow_q <= 1'b1;
    end
  end

  assign level = {{FIFO_AW{1'b0}}, valid_q};
  assign empty = !valid_q;
`endif
endmodule

// File: tb/tb_cereal_rx.sv
// tb_cereal_rx: directed plus randomized frames for cereal_rx, checked against a queue model of the buffer.
module tb_cereal_rx;
  localparam int CPB = 16;
  localparam int AW  = 2;
`ifdef CEREAL_RX_FIFO_EN
  localparam int DEPTH = 1 << AW;
`else
  localparam int DEPTH = 1;
`endif
  // Tick (1-based from the start-bit drive) whose rising edge samples the stop bit.
  localparam int PUSH_TICK = 2 + CPB / 2 + 9 * CPB + 1;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1, rxd = 1'b1, rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty, busy, frame_err, overflow;
  logic [AW:0]   level;

  int n_checks = 0, n_fail = 0, fe_count = 0, fall_tick = -1;

  logic [7:0] mq[$];
  logic       ovf_m = 1'b0;
  logic [7:0] last_head = 8'h00;

  cereal_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .sysclk(sysclk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .level(level), .busy(busy), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) if (frame_err === 1'b1) fe_count <= fe_count + 1;

  function automatic void m_reset();
    mq.delete();
    ovf_m     = 1'b0;
    last_head = 8'h00;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else ovf_m = 1'b1;
    if (mq.size() > 0) last_head = mq[0];
  endfunction

  function automatic void m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
    if (mq.size() > 0) last_head = mq[0];
  endfunction

  function automatic logic [7:0] exp_head();
    return (mq.size() > 0) ? mq[0] : last_head;
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"},    32'(level),   32'(mq.size()));
    check({tag, "_empty"},    32'(empty),   32'(mq.size() == 0));
    check({tag, "_rd_data"},  32'(rd_data), 32'(exp_head()));
    check({tag, "_overflow"}, 32'(overflow), 32'(ovf_m));
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_head"}, 32'(rd_data), 32'(exp_head()));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    m_pop();
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_one(tag);
    check({tag, "_drained_empty"}, 32'(empty), 32'd1);
  endtask

  // Drives one frame; optional pop at pop_tick, pops every 40 ticks, or a one-cycle reset at rst_tick.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_tick,
                            input int rst_tick, input bit pop_every);
    logic [9:0] bits;
    int n;
    bits = {stop_bit, b, 1'b0};
    n = 0;
    fall_tick = -1;
    for (int s = 0; s < 10; s++) begin
      for (int t = 0; t < CPB; t++) begin
        n++;
        rxd   = bits[s];
        rd_en = (n == pop_tick) || (pop_every && (n % 40 == 20));
        rst   = (n == rst_tick);
        if (rd_en && mq.size() > 0) check("pop_head", 32'(rd_data), 32'(exp_head()));
        tick();
        if (rst) begin
          rst   = 1'b0;
          rd_en = 1'b0;
          rxd   = 1'b1;
          m_reset();
          return;
        end
        if (rd_en) m_pop();
        if (n == PUSH_TICK && stop_bit) m_push(b);
        if (fall_tick < 0 && empty === 1'b0) fall_tick = n;
      end
    end
    rd_en = 1'b0;
    rxd   = 1'b1;
  endtask

  initial begin
    int fe0;
    int fe_exp;
    bit saw_busy;
    logic [7:0] b;
    logic good;
    int pt;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_reset();
    tick();
    check("reset_rd_data", 32'(rd_data), 32'h00);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_level", 32'(level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    idle(5);

    // Single byte
    fe0 = fe_count;
    send_frame(8'h48, 1'b1, 0, 0, 1'b0);
    check("single_fall_time", 32'(fall_tick >= 150 && fall_tick <= 158), 32'd1);
    check("single_data", 32'(rd_data), 32'h48);
    check("single_level1", 32'(level), 32'd1);
    check("single_no_ferr", 32'(fe_count - fe0), 32'd0);
    check_state("single");
    drain("single");

    // Back-to-back "HI!"
    fe0 = fe_count;
    send_frame(8'h48, 1'b1, 0, 0, 1'b0);
    send_frame(8'h49, 1'b1, 0, 0, 1'b0);
    send_frame(8'h21, 1'b1, 0, 0, 1'b0);
    idle(4);
    check("hi_level", 32'(level), 32'((DEPTH < 3) ? DEPTH : 3));
    check("hi_no_ferr", 32'(fe_count - fe0), 32'd0);
    check_state("hi");
    drain("hi");

    // Glitch on an idle line
    fe0 = fe_count;
    saw_busy = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) rxd = 1'b1;
      tick();
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    check("glitch_saw_busy", 32'(saw_busy), 32'd1);
    check("glitch_busy_done", 32'(busy), 32'd0);
    check("glitch_no_ferr", 32'(fe_count - fe0), 32'd0);
    check_state("glitch");

    // Framing error then a good byte
    fe0 = fe_count;
    send_frame(8'h55, 1'b0, 0, 0, 1'b0);
    idle(40);
    check("ferr_one_pulse", 32'(fe_count - fe0), 32'd1);
    check_state("ferr");
    send_frame(8'h41, 1'b1, 0, 0, 1'b0);
    idle(4);
    check("ferr_next_data", 32'(rd_data), 32'h41);
    check("ferr_no_extra", 32'(fe_count - fe0), 32'd1);
    check_state("ferr_next");
    drain("ferr");

    // Overflow, coincident push/pop at full, pointer wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) send_frame(8'(8'h30 + i), 1'b1, 0, 0, 1'b0);
    idle(4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(rd_data), 32'h30);
    check_state("ovf");
    send_frame(8'h35, 1'b1, PUSH_TICK, 0, 1'b0);
    idle(4);
    check_state("ovf_coincident");
    send_frame(8'h36, 1'b1, 0, 0, 1'b1);
    idle(4);
    check_state("ovf_wrap");
    drain("ovf");

    // Reset during the 4th data bit
    send_frame(8'hA5, 1'b1, 0, 4 * CPB + 8, 1'b0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check_state("midrst");
    idle(20);
    send_frame(8'h7A, 1'b1, 0, 0, 1'b0);
    idle(4);
    check("midrst_next_data", 32'(rd_data), 32'h7A);
    check_state("midrst_next");
    drain("midrst");

    // Randomized frames
    fe_exp = fe_count;
    for (int i = 0; i < 14; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      pt   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(10, 140)) : 0;
      send_frame(b, good, pt, 0, 1'b0);
      if (!good) begin
        fe_exp++;
        idle(40);
      end else if ($urandom_range(0, 1) != 0) begin
        idle(int'($urandom_range(1, 20)));
      end
      check_state("rand");
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        drain("rand");
      end
    end
    idle(4);
    check("rand_ferr_count", 32'(fe_count), 32'(fe_exp));
    drain("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cereal_rx.md
# cereal_rx

Serial character receiver that sits directly downstream of the word board's `out` line. Decodes the idle-high, LSB-first, 8-data-bit, 1-stop-bit frames produced by the `cereal` transmitter and recovers the ASCII bytes. Buffers the bytes in a small first-word-fall-through FIFO for a consumer, such as a display driver or loopback checker. Flags framing errors and buffer overflow.

## Interface
- `CLKS_PER_BIT`, default 78105: `sysclk` cycles per serial bit. Must match the transmitter's bit period; minimum 4.
- `FIFO_AW`, default 4: FIFO address width; depth = 2**FIFO_AW.
- `sysclk` in 1: system clock. All logic runs on its rising edge.
- `rst` in 1: reset. **Synchronous, active-high.**
- `rxd` in 1: serial line from `wordboard.out`. Asynchronous to `sysclk`; idle high.
- `rd_en` in 1: consumer pops the head entry this cycle.
- `rd_data` out 8: head entry of the FIFO. Valid whenever `empty`=0.
- `empty` out 1: FIFO holds no bytes.
- `level` out FIFO_AW+1: number of stored bytes.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overflow` out 1: sticky flag; set when a good byte arrives while the FIFO is full. Cleared only by `rst`.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-FF synchronizer. Both flops reset to 1. All decoding uses the synchronized bit `rx_s`.
- **Bit timer:** a counter of width clog2(CLKS_PER_BIT). It is zeroed on every state change and otherwise counts up.
- **State machine** (IDLE, START, DATA, STOP):
  - IDLE: when `rx_s`=0, go to START.
  - START: at count = CLKS_PER_BIT/2−1 (mid start bit), sample `rx_s`. If 0, go to DATA with bit index = 0. If 1, treat it as a glitch: return to IDLE with nothing pushed and no error.
  - DATA: at count = CLKS_PER_BIT−1, sample `rx_s` and shift it in at bit 7 of the shift register (right shift; LSB first). Increment the bit index. After the 8th sample, go to STOP.
  - STOP: at count = CLKS_PER_BIT−1 (mid stop bit), sample `rx_s`. If 1, push the shift register. If 0, pulse `frame_err` and discard the byte. In both cases go to IDLE in the same cycle, so a back-to-back start edge is caught.
- **FIFO:**
  - Push happens only from a good STOP sample.
  - A pop happens when `rd_en`=1 and `empty`=0. `rd_en` while empty is ignored.
  - Push while full and no pop in the same cycle: the byte is dropped, `overflow` is set, and contents are unchanged.
  - Simultaneous push and pop while full: both take effect; `level` is unchanged and `overflow` is not set.
  - Simultaneous push and pop while empty: only the push takes effect.
  - Pointers are FIFO_AW bits and wrap modulo the depth. `level` = writes − pops and never exceeds 2**FIFO_AW.
- **Reset:** `rst` mid-frame abandons the frame, returns to IDLE, and empties the FIFO.

## Timing
- **Reset values:**
  - `rd_data` = 8'h00
  - `empty` = 1
  - `level` = 0
  - `busy` = 0
  - `frame_err` = 0
  - `overflow` = 0
- **Start detection:** a falling edge on `rxd` reaches `rx_s` after 2 cycles. START is entered on the cycle after that.
- **Push timing:** the push occurs (CLKS_PER_BIT/2) + 9·CLKS_PER_BIT cycles after START entry, ±1 cycle. `empty` falls and `rd_data` updates on the cycle after the push edge, i.e. registered outputs.
- **Pop timing:** after a pop, the new head appears on `rd_data` the following cycle. When the FIFO goes empty, `rd_data` holds its last value.
- **`frame_err`:** high for exactly one cycle, coincident with the STOP-to-IDLE transition.
- **Throughput:** accepts continuous frames with zero idle bits between the stop bit and the next start bit.

## Configuration
- **`CEREAL_RX_FIFO_EN` defined:** FIFO of depth 2**FIFO_AW as described above.
- **`CEREAL_RX_FIFO_EN` undefined:**
  - The FIFO is replaced by a single holding register. Depth is 1; `FIFO_AW` is ignored; `level` is 0 or 1 (upper bits tie to 0).
  - All ports keep the same names and meanings.
  - Full is `level`=1. Overflow and simultaneous push/pop rules apply as for a depth-1 FIFO.

## Test plan
The bench uses CLKS_PER_BIT=16 and FIFO_AW=2.
- **Single byte:** reset, then drive 0x48 ('H') framed as 0, LSB-first data, 1. Required: `empty` falls about 152 cycles after the start edge; `rd_data`=0x48; `level`=1; `frame_err` never pulses.
- **Back-to-back string:** send "HI!" with no idle gap, `rd_en` held 0. Required: `level`=3; then pop three times to read 0x48, 0x49, 0x21 in order; after the last pop `empty`=1.
- **Glitch:** drive a 4-cycle low pulse on an idle line. Required: `busy` returns to 0 within 12 cycles; nothing is pushed; `frame_err`=0.
- **Framing error:** send 0x55 with the stop bit driven 0. Required: one-cycle `frame_err` pulse, `level` unchanged, and the next valid 0x41 is received correctly.
- **Overflow and wrap:**
  - Send 5 bytes 0x30..0x34 with no pops. Required: `level`=4 and `overflow`=1, with 0x30..0x33 retained.
  - Then pop 4 while sending 0x35, including one push coincident with a pop at full. Required: order is preserved across pointer wrap.
- **Reset mid-frame:** assert `rst` for 1 cycle during the 4th data bit. Required: next cycle shows `busy`=0, `empty`=1, `overflow`=0; a following frame 0x7A is received correctly.
